// File: rtl/raster_scan_gen.sv
// -----------------------------------------------------------------------------
// raster_scan_gen
//
// Pixel-scan generator feeding the triangle inside/outside test stage. On an
// accepted `start` it latches the three triangle vertices, then walks the
// scan window in print order (rows top to bottom, columns left to right),
// presenting one (px, py) coordinate per valid/ready handshake together with
// the latched vertices, so the downstream stage sees a constant triangle for
// the whole frame.
//
// Optional feature (compile-time macro RASTER_BBOX_EN):
//   defined   : the scan window is the triangle's bounding box clipped to the
//               grid; an off-grid box yields an empty frame (done, no beats).
//   undefined : the scan window is the full grid and no min/max logic exists.
//
// Parameters
//   W            coordinate width in bits
//   MAX_LINHAS   top row index (rows MAX_LINHAS..0)
//   MAX_COLUNAS  last column index (columns 0..MAX_COLUNAS)
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin a frame; only honoured in IDLE
//   ax..cy              triangle vertices, sampled on the accepted start
//   tri_ax..tri_cy      latched vertices, stable for the whole frame
//   pix_valid/pix_ready coordinate handshake
//   px, py              current pixel coordinate
//   end_of_line         current beat is the last column of its row
//   end_of_frame        current beat is the last pixel of the frame
//   busy                high in LOAD and SCAN
//   done                one-cycle pulse after the frame completes
// -----------------------------------------------------------------------------
module raster_scan_gen #(
  parameter int W           = 10,
  parameter int MAX_LINHAS  = 50,
  parameter int MAX_COLUNAS = 75
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  output logic [W-1:0] tri_ax,
  output logic [W-1:0] tri_ay,
  output logic [W-1:0] tri_bx,
  output logic [W-1:0] tri_by,
  output logic [W-1:0] tri_cx,
  output logic [W-1:0] tri_cy,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [W-1:0] px,
  output logic [W-1:0] py,
  output logic         end_of_line,
  output logic         end_of_frame,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [W-1:0] COL_MAX = W'(MAX_COLUNAS);
  localparam logic [W-1:0] ROW_MAX = W'(MAX_LINHAS);

  logic [1:0]   state;

  // Scan window. It is derived combinationally from the latched vertices,
  // which cannot change until the next accepted start (only possible in
  // IDLE), so it stays valid for the whole LOAD/SCAN span without its own
  // registers.
  logic [W-1:0] winXLo;
  logic [W-1:0] winXHi;
  logic [W-1:0] winYLo;
  logic [W-1:0] winYHi;
  logic         winEmpty;

`ifdef RASTER_BBOX_EN
  function automatic logic [W-1:0] min3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // NOTE: every signal written in always_comb gets an unconditional value
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    winXLo = min3(tri_ax, tri_bx, tri_cx);
    winXHi = max3(tri_ax, tri_bx, tri_cx);
    winYLo = min3(tri_ay, tri_by, tri_cy);
    winYHi = max3(tri_ay, tri_by, tri_cy);
    if (winXHi > COL_MAX) winXHi = COL_MAX;
    if (winYHi > ROW_MAX) winYHi = ROW_MAX;
    // A low corner beyond the grid means no pixel of the box is on-grid.
    winEmpty = (winXLo > COL_MAX) || (winYLo > ROW_MAX);
  end
`else
  assign winXLo   = '0;
  assign winXHi   = COL_MAX;
  assign winYLo   = '0;
  assign winYHi   = ROW_MAX;
  assign winEmpty = 1'b0;
`endif

  // Coordinate of the beat that follows the one currently presented.
  logic [W-1:0] nextX;
  logic [W-1:0] nextY;

  always_comb begin
    nextX = px;
    nextY = py;
    if (px < winXHi) begin
      nextX = px + 1'b1;
    end else begin
      nextX = winXLo;
      nextY = py - 1'b1;   // never below winYLo: the frame ends first
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tri_ax       <= '0;
      tri_ay       <= '0;
      tri_bx       <= '0;
      tri_by       <= '0;
      tri_cx       <= '0;
      tri_cy       <= '0;
      pix_valid    <= 1'b0;
      px           <= '0;
      py           <= '0;
      end_of_line  <= 1'b0;
      end_of_frame <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tri_ax <= ax;
            tri_ay <= ay;
            tri_bx <= bx;
            tri_by <= by;
            tri_cx <= cx;
            tri_cy <= cy;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          if (winEmpty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Present the top-left pixel of the window.
            px           <= winXLo;
            py           <= winYHi;
            pix_valid    <= 1'b1;
            end_of_line  <= (winXLo == winXHi);
            end_of_frame <= (winXLo == winXHi) && (winYHi == winYLo);
            state        <= SCAN;
          end
        end

        SCAN: begin
          // pix_valid is always high here, so pix_ready alone marks a transfer.
          if (pix_ready) begin
            if (end_of_frame) begin
              pix_valid    <= 1'b0;
              end_of_line  <= 1'b0;
              end_of_frame <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              px           <= nextX;
              py           <= nextY;
              end_of_line  <= (nextX == winXHi);
              end_of_frame <= (nextX == winXHi) && (nextY == winYLo);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/raster_scan_gen.md
# raster_scan_gen

Sequential pixel-scan generator that sits directly upstream of the triangle inside/outside test stage. On `start` it latches the three triangle vertices and walks the pixel grid in print order: rows from `MAX_LINHAS` down to 0, columns from 0 up to `MAX_COLUNAS`. It emits one (px, py) coordinate per valid/ready handshake, together with the latched vertices, so the determinant stage sees a constant triangle for the whole frame.

## Interface
- `W`, 10: coordinate width in bits.
- `MAX_LINHAS`, 50: top row index; rows span MAX_LINHAS..0.
- `MAX_COLUNAS`, 75: last column index; columns span 0..MAX_COLUNAS.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a frame; sampled only in IDLE.
- `ax, ay, bx, by, cx, cy` input W each: triangle vertices, unsigned, sampled on the accepted `start`.
- `tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy` output W each: vertices latched at `start`, stable until the next accepted `start`.
- `pix_valid` output 1: a coordinate is presented.
- `pix_ready` input 1: downstream accepts the coordinate.
- `px, py` output W each: current pixel coordinate.
- `end_of_line` output 1: the current beat is the last column of its row.
- `end_of_frame` output 1: the current beat is the last pixel of the frame.
- `busy` output 1: high in LOAD and SCAN.
- `done` output 1: one-cycle pulse when the frame completes.

## Operation
- States and transitions:
  - IDLE: on `start`, go to LOAD; otherwise stay.
  - LOAD: compute the scan window; go to SCAN, or to DONE if the window is empty.
  - SCAN: go to DONE on the handshake of the `end_of_frame` beat.
  - DONE: go to IDLE.
- Scan window, full-grid build: x from 0 to MAX_COLUNAS; y from MAX_LINHAS down to 0.
- Handshake:
  - A beat transfers when `pix_valid && pix_ready`.
  - While `pix_valid && !pix_ready`, `px`, `py`, `end_of_line` and `end_of_frame` hold stable.
  - `pix_valid` never drops without a transfer, except on `rst`.
- Advance on transfer:
  - If x < x_hi, then x = x+1.
  - Otherwise x = x_lo and y = y-1.
- Flags:
  - `end_of_line` = (x == x_hi).
  - `end_of_frame` = (x == x_hi && y == y_lo).
- Counters are W bits. Row decrement never wraps below y_lo, because the frame ends first.
- `start` outside IDLE is ignored, with no effect on state or latched vertices.
- Reset values:
  - State IDLE.
  - `pix_valid`, `busy`, `done`, `end_of_line`, `end_of_frame` = 0.
  - `px`, `py` and all `tri_*` = 0.
- `rst` mid-frame: the next cycle is IDLE with reset values; the partial frame is abandoned and no `done` is issued.

## Timing
- Outputs are registered.
- `start` accepted at edge T:
  - LOAD during cycle T+1.
  - First `pix_valid` with (x_lo, y_hi) at T+2.
- Throughput is 1 beat per cycle with `pix_ready` held high.
- Full-grid frame is (MAX_LINHAS+1)*(MAX_COLUNAS+1) = 3876 beats by default.
- `done` is high the cycle after the final transfer; `busy` falls in that same cycle.
- Back-to-back: a new `start` is accepted at the earliest one cycle after `done`, i.e. in IDLE.
- Empty window (bbox build only): `done` at T+2 and zero beats.

## Configuration
- `RASTER_BBOX_EN` defined: LOAD computes a clipped bounding box.
  - x_lo = min(ax,bx,cx); x_hi = min(max(ax,bx,cx), MAX_COLUNAS).
  - y_lo = min(ay,by,cy); y_hi = min(max(ay,by,cy), MAX_LINHAS).
  - The window is empty if x_lo > MAX_COLUNAS or y_lo > MAX_LINHAS.
  - Only pixels inside the window are emitted, in the same order.
- `RASTER_BBOX_EN` undefined: x_lo=0, x_hi=MAX_COLUNAS, y_lo=0, y_hi=MAX_LINHAS. The window is never empty, and no min/max logic is built.

## Test plan
- Full grid, defaults, A(0,0) B(10,0) C(0,30), `pix_ready`=1:
  - First beat (0,50) at T+2.
  - `end_of_line` on every x=75 beat (51 times).
  - `end_of_frame` only on (75,0), at beat 3876.
  - `done` one cycle later.
- Backpressure: drop `pix_ready` for 3 cycles at beat (5,50), then randomly thereafter → coordinates hold stable while stalled; the sequence has no gaps or duplicates; total 3876 beats.
- `RASTER_BBOX_EN`, same triangle:
  - Beats x 0..10, y 30..0 = 341 transfers.
  - First (0,30), last (10,0) with `end_of_frame`.
- `RASTER_BBOX_EN`, all vertices at x=100 → no `pix_valid`; `done` at T+2.
- `rst` asserted at beat 200 → next cycle all outputs are reset values with no `done`; a new `start` then runs a complete 3876-beat frame.
- `start` pulsed with different vertices during SCAN → ignored; `tri_*` unchanged; frame completes normally.
